// File: rtl/ov7670_pkg.sv
// ov7670_pkg: pixel format enum and byte-pair to RGB565 conversion shared by the capture blocks.
package ov7670_pkg;
  typedef enum logic [1:0] {FMT_RGB565, FMT_RGB444, FMT_YLUMA, FMT_RSVD} pix_fmt_e;
  function automatic logic [15:0] to_rgb565(input pix_fmt_e fmt, input logic [7:0] b0, input logic [7:0] b1);
    return fmt == FMT_RGB444 ? {b0[3:0], b0[3], b1[7:4], b1[7:6], b1[3:0], b1[3]} :
           fmt == FMT_YLUMA  ? {b0[7:3], b0[7:2], b0[7:3]} : {b0, b1};
  endfunction
endpackage

// File: rtl/ov7670_pix_pack.sv
// ov7670_pix_pack: negedge input stage, byte pairing and format conversion into registered pixel/line events.
module ov7670_pix_pack
  import ov7670_pkg::*;
(
  input  logic        pclk,
  input  logic        rst,
  input  logic        vsync,
  input  logic        href,
  input  logic [7:0]  d,
  input  logic [1:0]  mode,
  output logic        vs_rise,
  output logic        pix_valid,
  output logic [15:0] pix_data,
  output logic        line_start,
  output logic        line_end,
  output logic        line_odd
);
  logic vsync_n, href_n, vs_prev, href_prev, phase, href_rise;
  logic [7:0] d_n, b0;
  pix_fmt_e mode_q;
  always_ff @(negedge pclk or posedge rst)
    if (rst) begin
      vsync_n <= 1'b0;
      href_n  <= 1'b0;
      d_n     <= '0;
    end else begin
      vsync_n <= vsync;
      href_n  <= href;
      d_n     <= d;
    end
  assign vs_rise   = vsync_n & ~vs_prev;
  assign href_rise = href_n & ~href_prev;
  // line events are suppressed during blanking so an aborted line never reports an error
  always_ff @(posedge pclk or posedge rst)
    if (rst) begin
      vs_prev    <= 1'b0;
      href_prev  <= 1'b0;
      phase      <= 1'b0;
      b0         <= '0;
      mode_q     <= FMT_RGB565;
      pix_valid  <= 1'b0;
      pix_data   <= '0;
      line_start <= 1'b0;
      line_end   <= 1'b0;
      line_odd   <= 1'b0;
    end else begin
      vs_prev    <= vsync_n;
      href_prev  <= href_n;
      pix_valid  <= 1'b0;
      line_start <= href_rise & ~vsync_n;
      line_end   <= ~href_n & href_prev & ~vsync_n;
      line_odd   <= phase;
      if (vs_rise) mode_q <= pix_fmt_e'(mode);
      if (vsync_n) phase <= 1'b0;
      else if (href_n) begin
        if (href_rise | ~phase) begin
          b0    <= d_n;
          phase <= 1'b1;
        end else begin
          phase     <= 1'b0;
          pix_valid <= 1'b1;
          pix_data  <= to_rgb565(mode_q, b0, d_n);
        end
      end
    end
endmodule

// File: rtl/ov7670_frame_capture.sv
// ov7670_frame_capture: decimates and clips camera pixels into sequential RGB565 frame-buffer writes,
// with frame counting and line-length error reporting.
module ov7670_frame_capture
  import ov7670_pkg::*;
#(
  parameter int SRC_W   = 640,
  parameter int H_DECIM = 4,
  parameter int V_DECIM = 4,
  parameter int OUT_W   = 160,
  parameter int OUT_H   = 120,
  parameter int ADDR_W  = 17
) (
  input  logic              pclk,
  input  logic              rst,
  input  logic              vsync,
  input  logic              href,
  input  logic [7:0]        d,
  input  logic [1:0]        mode,
  output logic [ADDR_W-1:0] addr,
  output logic [15:0]       dout,
  output logic              we,
  output logic              end_of_frame,
  output logic [7:0]        frame_cnt,
  output logic              line_err
);
  localparam int HMW = $clog2(H_DECIM + 1);
  localparam int VMW = $clog2(V_DECIM + 1);
  localparam int OCW = $clog2(OUT_W + 1);
  localparam int ORW = $clog2(OUT_H + 1);
  localparam logic [HMW-1:0] HM = HMW'(H_DECIM - 1);
  localparam logic [VMW-1:0] VM = VMW'(V_DECIM - 1);
  logic vs_rise, pix_valid, line_start, line_end, line_odd;
  logic [15:0] pix_data, h_cnt;
  logic [HMW-1:0] h_mod;
  logic [VMW-1:0] v_mod;
  logic [OCW-1:0] out_col;
  logic [ORW-1:0] out_row;
  ov7670_pix_pack u_pack (
    .pclk       (pclk),
    .rst        (rst),
    .vsync      (vsync),
    .href       (href),
    .d          (d),
    .mode       (mode),
    .vs_rise    (vs_rise),
    .pix_valid  (pix_valid),
    .pix_data   (pix_data),
    .line_start (line_start),
    .line_end   (line_end),
    .line_odd   (line_odd)
  );
  always_ff @(posedge pclk or posedge rst)
    if (rst) begin
      addr         <= '0;
      dout         <= '0;
      we           <= 1'b0;
      end_of_frame <= 1'b0;
      frame_cnt    <= '0;
      line_err     <= 1'b0;
      h_cnt        <= '0;
      h_mod        <= '0;
      v_mod        <= '0;
      out_col      <= '0;
      out_row      <= '0;
    end else begin
      end_of_frame <= vs_rise;
      we           <= 1'b0;
      if (vs_rise) begin
        frame_cnt <= frame_cnt + 8'd1;
        addr      <= '0;
        line_err  <= 1'b0;
        h_cnt     <= '0;
        h_mod     <= '0;
        v_mod     <= '0;
        out_col   <= '0;
        out_row   <= '0;
      end else begin
        if (we) addr <= addr + 1'b1;
        if (line_start) begin
          h_cnt   <= '0;
          h_mod   <= '0;
          out_col <= '0;
        end
        if (pix_valid) begin
          h_cnt <= h_cnt + 16'd1;
          h_mod <= (h_mod == HM) ? '0 : h_mod + 1'b1;
          if (h_mod == HM && out_col < OCW'(OUT_W)) begin
            out_col <= out_col + 1'b1;
            if (v_mod == VM && out_row < ORW'(OUT_H)) begin
              we   <= 1'b1;
              dout <= pix_data;
            end
          end
        end
        if (line_end) begin
          if (h_cnt != 16'(SRC_W) || line_odd) line_err <= 1'b1;
          v_mod <= (v_mod == VM) ? '0 : v_mod + 1'b1;
          if (v_mod == VM && out_row < ORW'(OUT_H)) out_row <= out_row + 1'b1;
        end
      end
    end
endmodule

// File: tb/tb_ov7670_frame_capture.sv
// tb_ov7670_frame_capture: directed frames on a small 8-pixel-wide configuration with 2x2 decimation
// and a 3x2 clip window, checking writes, formats, frame events, line errors and reset.
module tb_ov7670_frame_capture;
  logic       pclk = 1'b0, rst = 1'b1, vsync = 1'b0, href = 1'b0;
  logic [7:0] d = '0;
  logic [1:0] mode = 2'b00;
  logic [3:0] addr;
  logic [15:0] dout;
  logic we, end_of_frame, line_err;
  logic [7:0] frame_cnt;
  int checks = 0, errors = 0;
  int nw = 0, eofs = 0, base, eof_base;
  logic [3:0]  wa [64];
  logic [15:0] wd [64];
  bit hit;

  ov7670_frame_capture #(.SRC_W(8), .H_DECIM(2), .V_DECIM(2), .OUT_W(3), .OUT_H(2), .ADDR_W(4)) dut (
    .pclk(pclk), .rst(rst), .vsync(vsync), .href(href), .d(d), .mode(mode),
    .addr(addr), .dout(dout), .we(we), .end_of_frame(end_of_frame),
    .frame_cnt(frame_cnt), .line_err(line_err)
  );

  always #5 pclk = ~pclk;

  always @(negedge pclk) begin
    if (we === 1'b1) begin
      if (nw < 64) begin
        wa[nw] = addr;
        wd[nw] = dout;
      end
      nw++;
    end
    if (end_of_frame === 1'b1) eofs++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input logic v, input logic h, input logic [7:0] b);
    @(posedge pclk);
    #1;
    vsync = v;
    href  = h;
    d     = b;
  endtask

  task automatic send_line(input int row, input int npix, input bit extra, input bit fixed,
                           input logic [7:0] f0, input logic [7:0] f1);
    for (int c = 0; c < npix; c++) begin
      cyc(1'b0, 1'b1, fixed ? f0 : 8'(row));
      cyc(1'b0, 1'b1, fixed ? f1 : 8'(c));
    end
    if (extra) cyc(1'b0, 1'b1, 8'hEE);
    repeat (3) cyc(1'b0, 1'b0, 8'h00);
  endtask

  task automatic vs_pulse(input logic [7:0] exp_cnt);
    eof_base = eofs;
    repeat (4) cyc(1'b1, 1'b0, 8'h00);
    repeat (3) cyc(1'b0, 1'b0, 8'h00);
    chk("eof_pulses", eofs - eof_base, 1);
    chk("frame_cnt", frame_cnt, exp_cnt);
    chk("addr_after_vs", addr, 0);
    chk("line_err_after_vs", line_err, 0);
  endtask

  // rows 1,3 and columns 1,3,5 survive 2x2 decimation and the 3x2 clip
  task automatic std_frame();
    base = nw;
    for (int r = 0; r < 6; r++) send_line(r, 8, 1'b0, 1'b0, 8'h00, 8'h00);
    chk("std_nwrites", nw - base, 6);
    for (int i = 0; i < 6; i++) begin
      chk("std_addr", wa[base+i], i);
      chk("std_dout", wd[base+i], {8'(1 + 2 * (i / 3)), 8'(1 + 2 * (i % 3))});
    end
  endtask

  initial begin
    #12;
    chk("rst_addr", addr, 0);
    chk("rst_dout", dout, 0);
    chk("rst_we", we, 0);
    chk("rst_eof", end_of_frame, 0);
    chk("rst_frame_cnt", frame_cnt, 0);
    chk("rst_line_err", line_err, 0);
    rst = 1'b0;
    repeat (3) cyc(1'b0, 1'b0, 8'h00);

    std_frame();
    chk("std_line_err", line_err, 0);
    mode = 2'b01;
    vs_pulse(8'd1);

    base = nw;
    send_line(0, 8, 1'b0, 1'b1, 8'h0F, 8'hA5);
    mode = 2'b10;
    send_line(1, 8, 1'b0, 1'b1, 8'h0F, 8'hA5);
    chk("rgb444_nwrites", nw - base, 3);
    chk("rgb444_dout", wd[base], 16'hFD4A);
    chk("rgb444_dout_last", wd[base+2], 16'hFD4A);
    vs_pulse(8'd2);

    base = nw;
    send_line(0, 8, 1'b0, 1'b1, 8'h80, 8'h11);
    send_line(1, 8, 1'b0, 1'b1, 8'h80, 8'h11);
    chk("luma_nwrites", nw - base, 3);
    chk("luma_dout", wd[base], 16'h8410);
    mode = 2'b00;
    vs_pulse(8'd3);

    base = nw;
    eof_base = eofs;
    send_line(0, 8, 1'b0, 1'b0, 8'h00, 8'h00);
    for (int c = 0; c < 2; c++) begin
      cyc(1'b0, 1'b1, 8'h01);
      cyc(1'b0, 1'b1, 8'(c));
    end
    cyc(1'b0, 1'b1, 8'h01);
    repeat (10) cyc(1'b1, 1'b1, 8'h01);
    repeat (3) cyc(1'b1, 1'b0, 8'h00);
    repeat (3) cyc(1'b0, 1'b0, 8'h00);
    chk("abort_nwrites", nw - base, 1);
    chk("abort_dout", wd[base], 16'h0101);
    chk("abort_eof", eofs - eof_base, 1);
    chk("abort_frame_cnt", frame_cnt, 4);
    chk("abort_line_err", line_err, 0);

    send_line(0, 7, 1'b0, 1'b0, 8'h00, 8'h00);
    chk("short_line_err", line_err, 1);
    vs_pulse(8'd5);

    base = nw;
    send_line(0, 8, 1'b0, 1'b0, 8'h00, 8'h00);
    chk("exact_line_err", line_err, 0);
    send_line(1, 8, 1'b1, 1'b0, 8'h00, 8'h00);
    chk("odd_nwrites", nw - base, 3);
    chk("odd_line_err", line_err, 1);
    vs_pulse(8'd6);

    for (int r = 0; r < 3; r++) send_line(r, 8, 1'b0, 1'b0, 8'h00, 8'h00);
    hit = 1'b0;
    for (int b = 0; b < 16 && !hit; b++) begin
      cyc(1'b0, 1'b1, b % 2 == 0 ? 8'h03 : 8'(b / 2));
      if (we === 1'b1) hit = 1'b1;
    end
    chk("pre_rst_we_seen", hit, 1);
    chk("pre_rst_addr", addr, 3);
    rst  = 1'b1;
    href = 1'b0;
    #1;
    chk("mid_rst_we", we, 0);
    chk("mid_rst_addr", addr, 0);
    chk("mid_rst_frame_cnt", frame_cnt, 0);
    chk("mid_rst_line_err", line_err, 0);
    #20;
    rst = 1'b0;
    repeat (3) cyc(1'b0, 1'b0, 8'h00);
    vs_pulse(8'd1);
    std_frame();
    vs_pulse(8'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
